muldiv_exec_unit: RTL and testbench



---
 rtl/muldiv_exec_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_exec_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/muldiv_exec_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, result and rd registered on entry to DONE.
//
// state | meaning
// IDLE  | waiting for StartE; operands latched on accept
// CALC  | XLEN iterations of multiply or divide; BusyE stalls the pipeline
// DONE  | one-cycle DoneE pulse with MulDivResultE/RdOutE valid
module muldiv_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic [4:0]      RdOutE
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [2:0]      funct;
  logic [4:0]      rd_q;
  logic [XLEN:0]   acc_hi;
  logic [XLEN-1:0] acc_lo, opnd;
  logic            neg_res, neg_rem, div_zero;

  logic            accept, last;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]   a_mag_w, b_mag_w;
  logic [XLEN:0]   mul_sum, div_shift, div_diff, hi_nxt;
  logic [XLEN-1:0] lo_nxt, quo_s, rem_s, result;
  logic            div_ge;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept = (state == IDLE) && StartE && !FlushE;
  assign last   = (state == CALC) && (count == CW'(XLEN-1));

  always_ff @(negedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BusyE     = 1'b0;
    DoneE     = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        BusyE = 1'b1;
        if (FlushE)    state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        DoneE     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes are formed in XLEN+1 bits so the most negative operand is exact.
  always_comb begin
    a_signed = (Funct3E == 3'b001) || (Funct3E == 3'b010) ||
               (Funct3E == 3'b100) || (Funct3E == 3'b110);
    b_signed = (Funct3E == 3'b001) || (Funct3E == 3'b100) || (Funct3E == 3'b110);
    a_neg    = a_signed && SrcAE[XLEN-1];
    b_neg    = b_signed && SrcBE[XLEN-1];
    a_mag_w  = a_neg ? -{1'b1, SrcAE} : {1'b0, SrcAE};
    b_mag_w  = b_neg ? -{1'b1, SrcBE} : {1'b0, SrcBE};
  end

  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[XLEN];
    if (funct[2]) begin
      hi_nxt = div_ge ? div_diff : div_shift;
      lo_nxt = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = {1'b0, mul_sum[XLEN:1]};
      lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Final result is taken from the last iteration's outputs at the CALC->DONE edge.
  always_comb begin
    prod   = {hi_nxt[XLEN-1:0], lo_nxt};
    prod_s = neg_res ? -prod : prod;
    quo_s  = div_zero ? '1 : (neg_res ? -lo_nxt : lo_nxt);
    rem_s  = neg_rem ? -hi_nxt[XLEN-1:0] : hi_nxt[XLEN-1:0];
    case (funct)
      3'b000:                 result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo_s;
      default:                result = rem_s;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      count         <= '0;
      funct         <= '0;
      rd_q          <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      opnd          <= '0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      div_zero      <= 1'b0;
      MulDivResultE <= '0;
      RdOutE        <= '0;
    end else if (accept) begin
      count    <= '0;
      funct    <= Funct3E;
      rd_q     <= RdE;
      acc_hi   <= '0;
      acc_lo   <= Funct3E[2] ? a_mag_w[XLEN-1:0] : b_mag_w[XLEN-1:0];
      opnd     <= Funct3E[2] ? b_mag_w[XLEN-1:0] : a_mag_w[XLEN-1:0];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (SrcBE == '0);
    end else if (state == CALC && !FlushE) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      count  <= count + CW'(1);
      if (last) begin
        MulDivResultE <= result;
        RdOutE        <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Directed bench for muldiv_exec_unit: drives on posedge+1, DUT updates on negedge.
module tb_muldiv_exec_unit;

  logic        clk = 1'b0;
  logic        rst, StartE, FlushE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        BusyE, DoneE;
  logic [31:0] MulDivResultE;
  logic [4:0]  RdOutE;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .FlushE(FlushE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .BusyE(BusyE), .DoneE(DoneE),
    .MulDivResultE(MulDivResultE), .RdOutE(RdOutE)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd);
    int busy = 0;
    while (BusyE === 1'b1 && busy < 100) begin
      busy++;
      step();
    end
    check({tag, " busy_cycles"}, busy, 32);
    check({tag, " done"}, {31'b0, DoneE}, 1);
    check({tag, " result"}, MulDivResultE, exp_res);
    check({tag, " rd"}, {27'b0, RdOutE}, {27'b0, exp_rd});
    step();
    check({tag, " done_one_cycle"}, {31'b0, DoneE}, 0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
    Funct3E = f; SrcAE = a; SrcBE = b; RdE = rd; StartE = 1'b1;
    step();
    StartE = 1'b0;
    wait_done(tag, exp_res, rd);
  endtask

  initial begin
    rst = 1'b1; StartE = 1'b0; FlushE = 1'b0; Funct3E = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (3) step();
    check("reset busy", {31'b0, BusyE}, 0);
    check("reset done", {31'b0, DoneE}, 0);
    check("reset result", MulDivResultE, 0);
    check("reset rd", {27'b0, RdOutE}, 0);
    rst = 1'b0;
    step();

    do_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB);
    do_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000);
    do_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE);
    do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF);
    do_op("divu",   3'b101, 32'd100,      32'd7,        5'd5,  32'd14);
    do_op("remu",   3'b111, 32'd100,      32'd7,        5'd6,  32'd2);
    do_op("div",    3'b100, 32'hFFFFFF9C, 32'd7,        5'd7,  32'hFFFFFFF2);
    do_op("rem",    3'b110, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFFE);
    do_op("div0",   3'b100, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF);
    do_op("rem0",   3'b110, 32'd5,        32'd0,        5'd10, 32'd5);
    do_op("divu0",  3'b101, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF);
    do_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000);
    do_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0);

    // Flush on the 10th CALC cycle, then restart from the following IDLE cycle.
    Funct3E = 3'b100; SrcAE = 32'd1000; SrcBE = 32'd3; RdE = 5'd14; StartE = 1'b1;
    step();
    StartE = 1'b0;
    repeat (9) step();
    check("flush pre busy", {31'b0, BusyE}, 1);
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    check("flush busy", {31'b0, BusyE}, 0);
    check("flush done", {31'b0, DoneE}, 0);
    check("flush result_held", MulDivResultE, 32'd0);
    do_op("after_flush", 3'b000, 32'd6, 32'd7, 5'd15, 32'd42);

    // StartE with FlushE in IDLE is not accepted.
    Funct3E = 3'b000; SrcAE = 32'd2; SrcBE = 32'd2; RdE = 5'd16; StartE = 1'b1; FlushE = 1'b1;
    step();
    StartE = 1'b0; FlushE = 1'b0;
    check("start_flush busy", {31'b0, BusyE}, 0);
    step();
    check("start_flush idle", {31'b0, BusyE}, 0);

    // StartE held through CALC and DONE: operands changed mid-op must not leak in.
    Funct3E = 3'b000; SrcAE = 32'd3; SrcBE = 32'd5; RdE = 5'd17; StartE = 1'b1;
    step();
    Funct3E = 3'b101; SrcAE = 32'd100; SrcBE = 32'd100; RdE = 5'd18;
    wait_done("hold", 32'd15, 5'd17);
    check("hold idle_gap", {31'b0, BusyE}, 0);
    step();
    StartE = 1'b0;
    wait_done("hold_second", 32'd1, 5'd18);

    // Reset in the middle of CALC.
    Funct3E = 3'b000; SrcAE = 32'h12345; SrcBE = 32'd3; RdE = 5'd20; StartE = 1'b1;
    step();
    StartE = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", {31'b0, BusyE}, 0);
    check("midrst done", {31'b0, DoneE}, 0);
    check("midrst result", MulDivResultE, 0);
    check("midrst rd", {27'b0, RdOutE}, 0);
    step();
    check("midrst stays_idle", {31'b0, BusyE}, 0);
    do_op("after_rst", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
